// File: rtl/cmd_frame_tx.sv
// Command frame transmitter: sends a 'CM' header word followed by FRAME_LEN-1 payload words over a cs-strobed 16-bit link.
// Optional macro CMD_TX_CHECKSUM_EN replaces the last payload word with the mod-2^16 sum of the preceding payload words.
module cmd_frame_tx #(
    parameter int unsigned FRAME_LEN = 50,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HIGH_CYC  = 4,
    parameter int unsigned LOW_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] rd_data,
    output logic        rd_en,
    output logic [5:0]  rd_addr,
    output logic [15:0] byteToEth,
    output logic        cs,
    output logic        busy,
    output logic        done
);

    localparam int unsigned MAX_HL  = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int unsigned MAX_CYC = (SETUP_CYC > MAX_HL) ? SETUP_CYC : MAX_HL;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned WCNT_W  = 7;
    localparam logic [15:0] HEADER  = 16'h434D;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_FETCH, S_LOAD
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [WCNT_W-1:0]   wcnt, wcnt_d;
    logic                cs_d, busy_d, done_d, rd_en_d;
    logic [5:0]          rd_addr_d;
    logic [15:0]         byte_d;
    logic                last_word_c;

    // Next word loaded is the final word of the frame
    assign last_word_c = (wcnt + WCNT_W'(1)) == WCNT_W'(FRAME_LEN);

`ifdef CMD_TX_CHECKSUM_EN
    logic [15:0] acc, acc_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wcnt      <= '0;
            cs        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            byteToEth <= '0;
`ifdef CMD_TX_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wcnt      <= wcnt_d;
            cs        <= cs_d;
            busy      <= busy_d;
            done      <= done_d;
            rd_en     <= rd_en_d;
            rd_addr   <= rd_addr_d;
            byteToEth <= byte_d;
`ifdef CMD_TX_CHECKSUM_EN
            acc       <= acc_d;
`endif
        end
    end

    // Next-state logic; done blocks a restart in the pulse cycle
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (start && !done) state_d = S_SETUP;
            S_SETUP: if (cnt == CNT_W'(SETUP_CYC - 1)) state_d = S_HIGH;
            S_HIGH:  if (cnt == CNT_W'(HIGH_CYC - 1)) state_d = S_LOW;
            S_LOW: begin
                if (cnt == CNT_W'(LOW_CYC - 1)) begin
                    state_d = (wcnt == WCNT_W'(FRAME_LEN)) ? S_IDLE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_SETUP;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values, keyed on the transition being taken
    always_comb begin
        cnt_d     = (state == S_IDLE || state_d != state) ? '0 : cnt + CNT_W'(1);
        wcnt_d    = wcnt;
        cs_d      = cs;
        busy_d    = busy;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr;
        byte_d    = byteToEth;
`ifdef CMD_TX_CHECKSUM_EN
        acc_d     = acc;
`endif
        unique case (state)
            S_IDLE: begin
                if (state_d == S_SETUP) begin
                    byte_d = HEADER;
                    busy_d = 1'b1;
                    wcnt_d = WCNT_W'(1);
`ifdef CMD_TX_CHECKSUM_EN
                    acc_d  = '0;
`endif
                end
            end
            S_SETUP: if (state_d == S_HIGH) cs_d = 1'b1;
            S_HIGH:  if (state_d == S_LOW) cs_d = 1'b0;
            S_LOW: begin
                if (state_d == S_IDLE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (state_d == S_FETCH) begin
`ifdef CMD_TX_CHECKSUM_EN
                    // Checksum word comes from the accumulator, not the register file
                    if (!last_word_c) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = 6'(wcnt - WCNT_W'(1));
                    end
`else
                    rd_en_d   = 1'b1;
                    rd_addr_d = 6'(wcnt - WCNT_W'(1));
`endif
                end
            end
            S_FETCH: ;
            S_LOAD: begin
                wcnt_d = wcnt + WCNT_W'(1);
`ifdef CMD_TX_CHECKSUM_EN
                if (last_word_c) begin
                    byte_d = acc;
                end else begin
                    byte_d = rd_data;
                    acc_d  = acc + rd_data;
                end
`else
                byte_d = rd_data;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cmd_frame_tx.md
CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

Interface
REQ-001 Parameter FRAME_LEN, default 50, words per frame including the 'CM' header word (legal 3..64).
REQ-002 Parameter SETUP_CYC, default 2, clk cycles byteToEth is held stable with cs low before cs rises (min 1).
REQ-003 Parameter HIGH_CYC, default 4, clk cycles cs is held high per word (min 1).
REQ-004 Parameter LOW_CYC, default 4, clk cycles cs is held low after the high phase (min 1).
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 start  input  1  frame request; sampled only in IDLE.
REQ-008 rd_data  input  16  payload word from the command register file, valid exactly one cycle after rd_en.
REQ-009 rd_en  output  1  payload read strobe, one cycle wide.
REQ-010 rd_addr  output  6  payload index 0..FRAME_LEN-2, valid while rd_en=1.
REQ-011 byteToEth  output  16  current word on the link.
REQ-012 cs  output  1  word strobe; receiver samples byteToEth on its rising edge.
REQ-013 busy  output  1  high from the first cycle after start is accepted until done.
REQ-014 done  output  1  one-cycle pulse after the last word's low phase.

Function
REQ-015 States: IDLE, SETUP, HIGH, LOW, FETCH, LOAD; all outputs are registered.
REQ-016 IDLE with start=1 at edge E0 -> byteToEth<=16'h434D, busy<=1, word counter<=1, state SETUP.
REQ-017 SETUP lasts SETUP_CYC cycles with cs=0; on exit cs<=1 and state HIGH.
REQ-018 HIGH lasts HIGH_CYC cycles; on exit cs<=0 and state LOW.
REQ-019 LOW lasts LOW_CYC cycles; on exit, if word counter=FRAME_LEN -> IDLE, busy<=0, done<=1, else -> FETCH.
REQ-020 FETCH is one cycle with rd_en=1 and rd_addr=word counter-1 (payload word k of the frame, k=2..FRAME_LEN, reads address k-2).
REQ-021 LOAD is one cycle: byteToEth<=rd_data, word counter incremented, state SETUP.
REQ-022 byteToEth changes only in IDLE start acceptance or LOAD; it never changes while cs=1 or in the cycle cs rises.
REQ-023 Header word period = SETUP_CYC+HIGH_CYC+LOW_CYC cycles; payload word period = that +2.
REQ-024 Defaults give 49 payload words and a frame of 10+49*12=598 cycles; done=1 in the cycle after edge E598.
REQ-025 start while busy=1 is ignored, not queued; start in the done cycle is ignored; start in the cycle after done is accepted.
REQ-026 Payload words equal to 16'h434D are sent unmodified (no escaping); it is the producer's job to avoid them.
REQ-027 cs is low in IDLE; byteToEth keeps the last sent word in IDLE.
REQ-028 rd_en is never asserted outside FETCH; rd_addr holds its last value otherwise.

Reset
REQ-029 rst=1 at any edge, including mid-frame, forces IDLE, cs=0, byteToEth=0, rd_en=0, rd_addr=0, busy=0, done=0, counters=0 after that edge.
REQ-030 rst takes priority over start in the same cycle; no partial frame resumes after reset.

Configuration
REQ-031 Macro CMD_TX_CHECKSUM_EN defined: word FRAME_LEN is the mod-2^16 sum of payload words 2..FRAME_LEN-1, sent from an internal accumulator; its FETCH cycle has rd_en=0 and LOAD takes the sum, keeping word timing identical.
REQ-032 Macro CMD_TX_CHECKSUM_EN undefined: word FRAME_LEN is rd_data from address FRAME_LEN-2, and no accumulator is built.
REQ-033 The accumulator clears on start acceptance and on rst.

Verification
REQ-034 Reset, then start pulse at E0 with defaults -> first cs rise after E2 with byteToEth=16'h434D; done pulse after E598; exactly 50 cs rises.
REQ-035 rd_data=16'h1000+addr -> words 2..50 on successive cs rises are 16'h1000..16'h1030; rd_addr runs 0..48, one rd_en per word.
REQ-036 start held high for the whole frame -> a second frame begins only on the edge after the done cycle, with no extra cs rises in between.
REQ-037 rst asserted during payload word 20's HIGH phase -> next cycle cs=0, busy=0, byteToEth=0; the next start produces a full header-first frame.
REQ-038 With CMD_TX_CHECKSUM_EN, rd_data=16'hFFFF for all addresses -> word 50 = (48*16'hFFFF) mod 2^16 = 16'hFFD0; rd_addr 48 is never read.
REQ-039 FRAME_LEN=3, SETUP_CYC=HIGH_CYC=LOW_CYC=1 -> 3 cs rises, done after E3+2*5=E13.
